sdio_spi_xfer: RTL and testbench

// - Parametrised full-duplex SPI slave datapath between host parallel bus and SD-side serial pins.
// - Host pushes TX words into a FIFO; they shift out MSB-first on DO.
// - DI is shifted in simultaneously and the assembled words are queued in an RX FIFO for host reads.
// - Replaces the fixed 8-bit TX-only FIFO/shift-out pair; adds RX, depth control, underrun fill and error flags.

---
 rtl/sdio_spi_xfer_pkg.sv | 16 +
 rtl/sdio_spi_xfer_sync_fifo.sv | 50 +++++
 rtl/sdio_spi_xfer.sv | 150 +++++++++++++++
 tb/tb_sdio_spi_xfer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdio_spi_xfer_pkg.sv
// Shared constants for the SD-card SPI slave datapath: SPI mode, error-flag
// bit positions and default word geometry.
package sdio_spi_xfer_pkg;

   localparam logic [1:0] SPI_MODE = 2'd0;
   localparam logic       SPI_CPOL = SPI_MODE[1];

   localparam int ERR_TX_UNDERRUN = 0;
   localparam int ERR_RX_OVERRUN  = 1;
   localparam int ERR_TX_OVERFLOW = 2;
   localparam int ERR_W           = 3;

   localparam int         DEFAULT_DW        = 8;
   localparam logic [7:0] DEFAULT_IDLE_FILL = 8'hFF;

endpackage

// File: rtl/sdio_spi_xfer_sync_fifo.sv
// Single-clock show-ahead FIFO with extra-MSB pointers; a push into a full
// FIFO is refused even when a pop happens in the same cycle.
module sdio_sync_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [DW-1:0]            i_din,
   input  logic                     i_pop,
   output logic [DW-1:0]            o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_level   = r_wr_ptr - r_rd_ptr;
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: storage is deliberately not reset; the pointers alone define validity.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/sdio_spi_xfer.sv
// Full-duplex SPI mode-0 slave: host TX FIFO shifted out MSB-first on DO while
// DI is assembled into words for the RX FIFO, all on the single ICLK domain.
module sdio_spi_xfer
   import sdio_spi_xfer_pkg::*;
#(
   parameter int            DW          = DEFAULT_DW,
   parameter int            TX_DEPTH    = 16,
   parameter int            RX_DEPTH    = 16,
   parameter int            SYNC_STAGES = 2,
   parameter logic [DW-1:0] IDLE_FILL   = DW'(DEFAULT_IDLE_FILL)
) (
   input  logic                        ICLK,
   input  logic                        ResetN,
   input  logic                        WriteN,
   input  logic [DW-1:0]               HostDin,
   input  logic                        RdN,
   output logic [DW-1:0]               HostDout,
   output logic                        TxFull,
   output logic [$clog2(TX_DEPTH):0]   TxLevel,
   output logic                        RxEmpty,
   output logic [ERR_W-1:0]            ErrFlags,
   input  logic                        ErrClrN,
   input  logic                        SCLK,
   input  logic                        CSn,
   input  logic                        DI,
   output logic                        DO,
   output logic                        DO_OE
);

   localparam int            BW       = $clog2(DW);
   localparam logic [BW-1:0] LAST_BIT = BW'(DW-1);

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_di_sync;
   logic                   r_sclk_d, r_csn_d;
   logic [BW-1:0]          r_bitcnt;
   logic [DW-2:0]          r_rx_shreg;
   logic [DW-1:0]          r_tx_shreg;
   logic                   r_first_fall;
   logic [ERR_W-1:0]       r_err;

   logic                   w_sclk_s, w_csn_s, w_di_s;
   logic                   w_frame_start, w_frame_end, w_sample, w_shift;
   logic                   w_load, w_tx_pop, w_rx_push;
   logic [DW-1:0]          w_rx_word, w_tx_dout;
   logic                   w_tx_empty, w_rx_full;
   logic [ERR_W-1:0]       w_err_set;
   logic [$clog2(RX_DEPTH):0] w_unused_rx_level;

   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_csn_s  = r_csn_sync[SYNC_STAGES-1];
   assign w_di_s   = r_di_sync[SYNC_STAGES-1];

   assign w_frame_start = !w_csn_s && r_csn_d;
   assign w_frame_end   = w_csn_s && !r_csn_d;
   // Edges landing on the frame-start cycle are dropped; the master must lead SCLK with CSn.
   assign w_sample = !w_csn_s && !w_frame_start && (w_sclk_s != r_sclk_d) && (w_sclk_s != SPI_CPOL);
   assign w_shift  = !w_csn_s && !w_frame_start && (w_sclk_s != r_sclk_d) && (w_sclk_s == SPI_CPOL);
   assign w_rx_word = {r_rx_shreg, w_di_s};

   assign DO       = r_tx_shreg[DW-1];
   assign DO_OE    = !w_csn_s;
   assign ErrFlags = r_err;

   always_ff @(posedge ICLK or negedge ResetN) begin
      if (!ResetN) begin
         r_sclk_sync <= {SYNC_STAGES{SPI_CPOL}};
         r_csn_sync  <= '1;
         r_di_sync   <= '0;
         r_sclk_d    <= SPI_CPOL;
         r_csn_d     <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
         r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], CSn};
         r_di_sync   <= {r_di_sync[SYNC_STAGES-2:0], DI};
         r_sclk_d    <= w_sclk_s;
         r_csn_d     <= w_csn_s;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      w_load    = 1'b0;
      w_tx_pop  = 1'b0;
      w_rx_push = 1'b0;
      w_err_set = '0;
      if (w_frame_start)
         w_load = 1'b1;
      else if (w_shift && r_bitcnt == '0 && !r_first_fall)
         w_load = 1'b1;
      if (w_load) begin
         w_tx_pop                   = !w_tx_empty;
         w_err_set[ERR_TX_UNDERRUN] = w_tx_empty;
      end
      if (w_sample && r_bitcnt == LAST_BIT) begin
         w_rx_push                 = !w_rx_full;
         w_err_set[ERR_RX_OVERRUN] = w_rx_full;
      end
      w_err_set[ERR_TX_OVERFLOW] = !WriteN && TxFull;
   end

   always_ff @(posedge ICLK or negedge ResetN) begin
      if (!ResetN) begin
         r_bitcnt     <= '0;
         r_rx_shreg   <= '0;
         r_tx_shreg   <= IDLE_FILL;
         r_first_fall <= 1'b0;
         r_err        <= '0;
      end else begin
         r_err <= (ErrClrN ? r_err : '0) | w_err_set;
         if (w_frame_start || w_frame_end)
            r_bitcnt <= '0;
         else if (w_sample)
            r_bitcnt <= (r_bitcnt == LAST_BIT) ? '0 : r_bitcnt + BW'(1);
         if (w_sample) r_rx_shreg <= w_rx_word[DW-2:0];
         if (w_load)
            r_tx_shreg <= w_tx_empty ? IDLE_FILL : w_tx_dout;
         else if (w_shift && r_bitcnt != '0)
            r_tx_shreg <= {r_tx_shreg[DW-2:0], 1'b1};
         if (w_frame_start)
            r_first_fall <= 1'b1;
         else if (w_shift)
            r_first_fall <= 1'b0;
      end
   end

   sdio_sync_fifo #(.DW(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .i_clk   (ICLK),
      .i_rst_n (ResetN),
      .i_push  (!WriteN),
      .i_din   (HostDin),
      .i_pop   (w_tx_pop),
      .o_dout  (w_tx_dout),
      .o_full  (TxFull),
      .o_empty (w_tx_empty),
      .o_level (TxLevel)
   );

   sdio_sync_fifo #(.DW(DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .i_clk   (ICLK),
      .i_rst_n (ResetN),
      .i_push  (w_rx_push),
      .i_din   (w_rx_word),
      .i_pop   (!RdN),
      .o_dout  (HostDout),
      .o_full  (w_rx_full),
      .o_empty (RxEmpty),
      .o_level (w_unused_rx_level)
   );

endmodule

// File: tb/tb_sdio_spi_xfer.sv
// Self-checking bench for sdio_spi_xfer: table-driven full-duplex frames plus
// hand-written underrun, overrun, overflow, abort and reset sequences.
module tb_sdio_spi_xfer;

   logic       ICLK = 1'b0;
   logic       ResetN, WriteN, RdN, ErrClrN, SCLK, CSn, DI;
   logic [7:0] HostDin, HostDout;
   logic       TxFull, RxEmpty, DO, DO_OE;
   logic [4:0] TxLevel;
   logic [2:0] ErrFlags;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] di;
      logic [7:0] exp_do;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t       vecs [4];
   logic [7:0] tx_q [$];
   logic [7:0] rx_q [$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] w;

   sdio_spi_xfer dut (
      .ICLK(ICLK), .ResetN(ResetN), .WriteN(WriteN), .HostDin(HostDin),
      .RdN(RdN), .HostDout(HostDout), .TxFull(TxFull), .TxLevel(TxLevel),
      .RxEmpty(RxEmpty), .ErrFlags(ErrFlags), .ErrClrN(ErrClrN),
      .SCLK(SCLK), .CSn(CSn), .DI(DI), .DO(DO), .DO_OE(DO_OE)
   );

   always #5 ICLK = ~ICLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ICLK);
      #2;
   endtask

   task automatic host_push(input logic [7:0] d);
      WriteN  = 1'b0;
      HostDin = d;
      tick(1);
      WriteN  = 1'b1;
   endtask

   task automatic clear_errors();
      ErrClrN = 1'b0;
      tick(1);
      ErrClrN = 1'b1;
   endtask

   // Mode-0 master: DO sampled before each rise, DI set up ahead of it;
   // end_frame raises CSn together with the final falling edge.
   task automatic spi_bits(input logic [7:0] di, input int nbits, input bit end_frame,
                           output logic [7:0] do_w);
      do_w = '0;
      for (int i = 0; i < nbits; i++) begin
         do_w[7-i] = DO;
         DI = di[7-i];
         tick(4);
         SCLK = 1'b1;
         tick(5);
         SCLK = 1'b0;
         if (end_frame && i == nbits-1) CSn = 1'b1;
         tick(4);
      end
   endtask

   task automatic rx_drain(input int n);
      logic [7:0] exp;
      for (int i = 0; i < n; i++) begin
         check("rx_not_empty", 32'(RxEmpty), 32'd0);
         exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
         check("rx_word", 32'(HostDout), 32'(exp));
         RdN = 1'b0;
         tick(1);
         RdN = 1'b1;
      end
   endtask

   task automatic check_do_word(input logic [7:0] act);
      logic [7:0] exp;
      exp = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
      check("do_word", 32'(act), 32'(exp));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ResetN = 1'b0; WriteN = 1'b1; HostDin = '0; RdN = 1'b1; ErrClrN = 1'b1;
      SCLK = 1'b0; CSn = 1'b1; DI = 1'b0;
      vecs[0] = '{tx: 8'hA5, di: 8'hC3, exp_do: 8'hA5, exp_rx: 8'hC3};
      vecs[1] = '{tx: 8'h3C, di: 8'h81, exp_do: 8'h3C, exp_rx: 8'h81};
      vecs[2] = '{tx: 8'h00, di: 8'hFF, exp_do: 8'h00, exp_rx: 8'hFF};
      vecs[3] = '{tx: 8'h96, di: 8'h5A, exp_do: 8'h96, exp_rx: 8'h5A};

      tick(3);
      check("rst_do", 32'(DO), 32'd1);
      check("rst_do_oe", 32'(DO_OE), 32'd0);
      check("rst_txfull", 32'(TxFull), 32'd0);
      check("rst_txlevel", 32'(TxLevel), 32'd0);
      check("rst_rxempty", 32'(RxEmpty), 32'd1);
      check("rst_hostdout", 32'(HostDout), 32'd0);
      check("rst_err", 32'(ErrFlags), 32'd0);
      ResetN = 1'b1;
      tick(2);

      // Table-driven full-duplex frame.
      for (int k = 0; k < 4; k++) begin
         host_push(vecs[k].tx);
         tx_q.push_back(vecs[k].exp_do);
      end
      check("tx_level_4", 32'(TxLevel), 32'd4);
      CSn = 1'b0;
      tick(8);
      check("do_oe_active", 32'(DO_OE), 32'd1);
      for (int k = 0; k < 4; k++) begin
         spi_bits(vecs[k].di, 8, (k == 3), w);
         rx_q.push_back(vecs[k].exp_rx);
         check_do_word(w);
      end
      tick(8);
      check("do_oe_idle", 32'(DO_OE), 32'd0);
      check("tx_level_0", 32'(TxLevel), 32'd0);
      check("err_clean", 32'(ErrFlags), 32'd0);
      rx_drain(4);
      check("rx_empty_after", 32'(RxEmpty), 32'd1);

      // TX underrun: idle fill and sticky flag, cleared by ErrClrN.
      CSn = 1'b0;
      tick(8);
      spi_bits(8'h00, 8, 1'b1, w);
      tick(8);
      check("underrun_fill", 32'(w), 32'hFF);
      check("underrun_flag", 32'(ErrFlags), 32'b001);
      rx_q.push_back(8'h00);
      rx_drain(1);
      clear_errors();
      check("err_cleared", 32'(ErrFlags), 32'd0);

      // RX overrun: 17th word dropped, first 16 kept.
      CSn = 1'b0;
      tick(8);
      for (int i = 0; i < 17; i++) begin
         spi_bits(8'(i * 3 + 1), 8, (i == 16), w);
         if (i < 16) rx_q.push_back(8'(i * 3 + 1));
      end
      tick(8);
      check("overrun_flag", 32'(ErrFlags[1]), 32'd1);
      rx_drain(16);
      check("rx_empty_overrun", 32'(RxEmpty), 32'd1);
      clear_errors();

      // TX overflow, then push coinciding with the frame-start pop.
      for (int i = 0; i < 17; i++) begin
         host_push(8'(8'h10 + i));
         if (i < 16) tx_q.push_back(8'(8'h10 + i));
      end
      check("txfull", 32'(TxFull), 32'd1);
      check("txlevel_full", 32'(TxLevel), 32'd16);
      check("overflow_flag", 32'(ErrFlags), 32'b100);
      clear_errors();
      CSn = 1'b0;
      tick(2);
      WriteN  = 1'b0;
      HostDin = 8'hEE;
      tick(1);
      WriteN  = 1'b1;
      check("push_pop_level", 32'(TxLevel), 32'd15);
      check("push_pop_flag", 32'(ErrFlags), 32'b100);
      tick(5);
      for (int i = 0; i < 16; i++) begin
         spi_bits(8'(~i), 8, (i == 15), w);
         rx_q.push_back(8'(~i));
         check_do_word(w);
      end
      tick(8);
      check("drain_level", 32'(TxLevel), 32'd0);
      check("drain_flags", 32'(ErrFlags), 32'b100);
      rx_drain(16);
      clear_errors();

      // Mid-word abort, then a fresh frame.
      host_push(8'h5A);
      CSn = 1'b0;
      tick(8);
      spi_bits(8'hFF, 3, 1'b1, w);
      tick(8);
      check("abort_bits", 32'(w[7:5]), 32'b010);
      check("abort_do_oe", 32'(DO_OE), 32'd0);
      check("abort_rx_empty", 32'(RxEmpty), 32'd1);
      host_push(8'h77);
      tx_q.push_back(8'h77);
      CSn = 1'b0;
      tick(8);
      spi_bits(8'h42, 8, 1'b1, w);
      tick(8);
      check_do_word(w);
      rx_q.push_back(8'h42);
      rx_drain(1);
      check("abort_rx_clean", 32'(RxEmpty), 32'd1);
      check("abort_err", 32'(ErrFlags), 32'd0);

      // Reset asserted mid-frame.
      host_push(8'h11);
      host_push(8'h22);
      CSn = 1'b0;
      tick(8);
      spi_bits(8'hC0, 2, 1'b0, w);
      check("pre_rst_do", 32'(DO), 32'd0);
      check("pre_rst_oe", 32'(DO_OE), 32'd1);
      check("pre_rst_level", 32'(TxLevel), 32'd1);
      ResetN = 1'b0;
      #1;
      check("mid_rst_do", 32'(DO), 32'd1);
      check("mid_rst_oe", 32'(DO_OE), 32'd0);
      check("mid_rst_level", 32'(TxLevel), 32'd0);
      check("mid_rst_full", 32'(TxFull), 32'd0);
      check("mid_rst_rxempty", 32'(RxEmpty), 32'd1);
      check("mid_rst_dout", 32'(HostDout), 32'd0);
      check("mid_rst_err", 32'(ErrFlags), 32'd0);
      tick(2);
      CSn = 1'b1;
      ResetN = 1'b1;
      tick(4);
      check("post_rst_level", 32'(TxLevel), 32'd0);
      check("post_rst_rxempty", 32'(RxEmpty), 32'd1);
      check("post_rst_oe", 32'(DO_OE), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
